// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock-enable generator for the mips core.
// Turns the board clock, a run switch and a step button into a stream of
// one-clk cpu_ce pulses. In RUN the pulses come at a divided rate chosen
// by div_sel. In STEP there is one pulse per debounced button press. The
// pulse rate is selected with div_sel.
//
// Optional feature: define CPU_STEP_BURST_EN to make each press in STEP
// issue BURST_LEN back-to-back pulses instead of a single pulse.
//
// Ports:
//   clk      - board clock; all logic runs on its rising edge.
//   rst_n    - asynchronous reset, active HIGH (1 = reset), name kept
//              from the board top.
//   run_sw   - asynchronous level; 1 = free-run, 0 = single-step.
//   step_btn - asynchronous raw push-button; 1 = pressed.
//   div_sel  - free-run rate select, used every cycle.
//   cpu_ce   - registered one-clk enable pulse to the CPU.
//   run_led  - 1 while in RUN.
//   ce_count - number of cpu_ce pulses since reset; wraps modulo 2^16.
module cpu_step_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int DIV0      = 1,
  parameter int DIV1      = 100,
  parameter int DIV2      = 1000000,
  parameter int DIV3      = 50000000,
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [1:0]  div_sel,
  output logic        cpu_ce,
  output logic        run_led,
  output logic [15:0] ce_count
);

  localparam int DBW  = $clog2(DB_CYCLES) + 1;
  localparam int DIVW = 27;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
    $error("cpu_step_ctrl: BURST_LEN must be in 1..255");
  end

  typedef enum logic {STEP = 1'b0, RUN = 1'b1} state_t;

  // Terminal divider value (period - 1) for a rate select.
  function automatic logic [DIVW-1:0] period_last(input logic [1:0] sel);
    case (sel)
      2'd0:    period_last = DIVW'(DIV0 - 1);
      2'd1:    period_last = DIVW'(DIV1 - 1);
      2'd2:    period_last = DIVW'(DIV2 - 1);
      default: period_last = DIVW'(DIV3 - 1);
    endcase
  endfunction

  // Bit 0 carries run_sw, bit 1 carries step_btn through both stages.
  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     db_lvl;
  logic [DBW-1:0] db_cnt [2];
  logic           step_db_q;
  logic           step_press;

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_last;
  logic [1:0]      div_sel_q;
  logic            sel_changed;

`ifdef CPU_STEP_BURST_EN
  localparam logic [7:0] BURST_REM = 8'(BURST_LEN - 1);
  logic [7:0] burst_cnt;
`endif

  // ---- stage p0/p1: two-flop synchronizers ----
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {step_btn, run_sw};
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce, counter restarts whenever the sample agrees ----
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      db_lvl    <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      step_db_q <= 1'b0;
    end else begin
      step_db_q <= db_lvl[1];
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced button only; release is ignored.
  assign step_press  = db_lvl[1] & ~step_db_q;
  assign div_last    = period_last(div_sel);
  assign sel_changed = (div_sel != div_sel_q);

  // ---- stage p3: mode FSM and registered enable ----
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= STEP;
      run_led   <= 1'b0;
      cpu_ce    <= 1'b0;
      div_cnt   <= '0;
      div_sel_q <= '0;
`ifdef CPU_STEP_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      div_sel_q <= div_sel;
      case (state)
        STEP: begin
          if (db_lvl[0]) begin
            state   <= RUN;
            run_led <= 1'b1;
            cpu_ce  <= 1'b0;
            div_cnt <= '0;
`ifdef CPU_STEP_BURST_EN
            burst_cnt <= '0;
`endif
          end else begin
`ifdef CPU_STEP_BURST_EN
            // burst_cnt holds the pulses still owed after the current one.
            if (burst_cnt != 8'd0) begin
              cpu_ce    <= 1'b1;
              burst_cnt <= burst_cnt - 8'd1;
            end else if (step_press) begin
              cpu_ce    <= 1'b1;
              burst_cnt <= BURST_REM;
            end else begin
              cpu_ce <= 1'b0;
            end
`else
            cpu_ce <= step_press;
`endif
          end
        end
        RUN: begin
          if (!db_lvl[0]) begin
            state   <= STEP;
            run_led <= 1'b0;
            cpu_ce  <= 1'b0;
            div_cnt <= '0;
          end else if (div_cnt >= div_last) begin
            // A rate change that leaves the divider at or past the new
            // terminal value restarts the period without a pulse.
            cpu_ce  <= (div_cnt == div_last) && !sel_changed;
            div_cnt <= '0;
          end else begin
            cpu_ce  <= 1'b0;
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
      endcase
    end
  end

  // ---- stage p4: pulse counter, trails cpu_ce by one clk ----
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ce_count <= '0;
    end else if (cpu_ce) begin
      ce_count <= ce_count + 16'd1;
    end
  end

endmodule
